// File: rtl/cpu_stage_sequencer.sv
// cpu_stage_sequencer: multicycle IF/ID/EX/MEM/WB stage controller.
// Optional performance counters are built only when STAGE_PERF_CNT_EN is defined;
// otherwise instr_count and stall_count are tied to zero.
//
// state | meaning
// ------+-----------------------------------------------------------
// IF    | fetch; instr_latch strobes while run=1
// ID    | decode
// EX    | execute; mem_access selects MEM or WB
// MEM   | data-bus access; counts wait states, aborts at MAX_WAIT
// WB    | writeback; pc_update strobes, wb_suppress after a timeout
module cpu_stage_sequencer #(
  parameter int STAGE_COUNT = 5,
  parameter int WAIT_WIDTH  = 4,
  parameter int MAX_WAIT    = 15,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   mem_access,
  input  logic                   bus_ready,
  output logic [STAGE_COUNT-1:0] pipeline_stage,
  output logic                   instr_latch,
  output logic                   pc_update,
  output logic                   wb_suppress,
  output logic                   bus_timeout,
  output logic [WAIT_WIDTH-1:0]  wait_count,
  output logic [CNT_WIDTH-1:0]   instr_count,
  output logic [CNT_WIDTH-1:0]   stall_count
);

  typedef enum logic [4:0] {
    S_IF  = 5'b00001,
    S_ID  = 5'b00010,
    S_EX  = 5'b00100,
    S_MEM = 5'b01000,
    S_WB  = 5'b10000
  } stage_t;

  localparam logic [WAIT_WIDTH-1:0] MAX_WAIT_C = WAIT_WIDTH'(MAX_WAIT);

  stage_t stage;
  logic   mem_wait;

  // A MEM cycle that is actually spent waiting on the bus (frozen cycles do not count).
  assign mem_wait = run && (stage == S_MEM) && !bus_ready;

  // Strobes are combinational so they land in the same cycle as the stage they mark.
  assign instr_latch    = run && (stage == S_IF);
  assign pc_update      = run && (stage == S_WB);
  assign pipeline_stage = STAGE_COUNT'(stage);

  // Stage sequencing, wait-state counting and timeout/suppress flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage       <= S_IF;
      wait_count  <= '0;
      bus_timeout <= 1'b0;
      wb_suppress <= 1'b0;
    end else begin
      case (stage)
        S_IF: if (run) stage <= S_ID;
        S_ID: if (run) stage <= S_EX;
        S_EX: begin
          if (run) begin
            wait_count <= '0;
            stage      <= mem_access ? S_MEM : S_WB;
          end
        end
        S_MEM: begin
          if (run) begin
            if (bus_ready) begin
              stage      <= S_WB;
              wait_count <= '0;
            end else if (wait_count == MAX_WAIT_C) begin
              // Hung access: abandon it, flag it, and block its writeback.
              stage       <= S_WB;
              wait_count  <= '0;
              bus_timeout <= 1'b1;
              wb_suppress <= 1'b1;
            end else begin
              wait_count <= wait_count + 1'b1;
            end
          end
        end
        S_WB: begin
          if (run) begin
            stage       <= S_IF;
            wb_suppress <= 1'b0;
          end
        end
        // Unreachable non-one-hot encodings fall back to fetch regardless of run.
        default: begin
          stage       <= S_IF;
          wait_count  <= '0;
          wb_suppress <= 1'b0;
        end
      endcase
    end
  end

`ifdef STAGE_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Saturating retired-instruction and bus-stall counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_count <= '0;
      stall_count <= '0;
    end else begin
      if (pc_update && (instr_count != CNT_MAX)) instr_count <= instr_count + 1'b1;
      if (mem_wait && (stall_count != CNT_MAX)) stall_count <= stall_count + 1'b1;
    end
  end
`else
  logic unused_mem_wait;
  assign unused_mem_wait = mem_wait;
  assign instr_count = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Self-checking bench for cpu_stage_sequencer: vector table, directed corner
// sequences, then random stimulus against an instruction-level reference model.
module tb_cpu_stage_sequencer;
  localparam int MAXW = 15;
`ifdef STAGE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b0, run = 1'b0, mem_access = 1'b0, bus_ready = 1'b0;
  logic [4:0]  stage, stage4;
  logic        il, pc, sup, tout, il4, pc4, sup4, tout4;
  logic [3:0]  wc, wc4;
  logic [15:0] ic, sc;
  logic [3:0]  ic4, sc4;

  int total = 0;
  int bad = 0;

  // reference model: stage index 0..4 = IF,ID,EX,MEM,WB
  int m_st, m_wc, m_icnt, m_scnt;
  bit m_tout, m_sup;

  always #5 clk = ~clk;

  cpu_stage_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .mem_access(mem_access), .bus_ready(bus_ready),
    .pipeline_stage(stage), .instr_latch(il), .pc_update(pc), .wb_suppress(sup),
    .bus_timeout(tout), .wait_count(wc), .instr_count(ic), .stall_count(sc));

  cpu_stage_sequencer #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .run(run), .mem_access(mem_access), .bus_ready(bus_ready),
    .pipeline_stage(stage4), .instr_latch(il4), .pc_update(pc4), .wb_suppress(sup4),
    .bus_timeout(tout4), .wait_count(wc4), .instr_count(ic4), .stall_count(sc4));

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_wc = 0; m_icnt = 0; m_scnt = 0; m_tout = 0; m_sup = 0;
  endtask

  task automatic model_step();
    if (!run) return;
    case (m_st)
      0: m_st = 1;
      1: m_st = 2;
      2: begin m_wc = 0; m_st = mem_access ? 3 : 4; end
      3: begin
        if (bus_ready) begin m_st = 4; m_wc = 0; end
        else begin
          m_scnt++;
          if (m_wc == MAXW) begin m_st = 4; m_wc = 0; m_tout = 1; m_sup = 1; end
          else m_wc++;
        end
      end
      default: begin m_st = 0; m_sup = 0; m_icnt++; end
    endcase
  endtask

  task automatic check_model();
    chk("stage", stage, 1 << m_st);
    chk("instr_latch", il, run && m_st == 0);
    chk("pc_update", pc, run && m_st == 4);
    chk("wb_suppress", sup, m_sup);
    chk("bus_timeout", tout, m_tout);
    chk("wait_count", wc, m_wc);
    chk("instr_count", ic, PERF ? sat(m_icnt, 65535) : 0);
    chk("stall_count", sc, PERF ? sat(m_scnt, 65535) : 0);
    chk("stage_w4", stage4, 1 << m_st);
    chk("flags_w4", {il4, pc4, sup4, tout4}, {il, pc, sup, tout});
    chk("wait_w4", wc4, m_wc);
    chk("instr_count_w4", ic4, PERF ? sat(m_icnt, 15) : 0);
    chk("stall_count_w4", sc4, PERF ? sat(m_scnt, 15) : 0);
  endtask

  task automatic tick_a(input bit r, input bit m, input bit b);
    run = r; mem_access = m; bus_ready = b;
    @(negedge clk);
    check_model();
  endtask

  task automatic tick_b();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic tick(input bit r, input bit m, input bit b);
    tick_a(r, m, b);
    tick_b();
  endtask

  task automatic run_to_if();
    for (int k = 0; k < 40 && m_st != 0; k++) tick(1, 0, 1);
    chk("run_to_if", stage, 1);
  endtask

  typedef struct {
    bit r, m, b;
    logic [4:0] st;
    bit il, pc, sup;
    int wc;
  } vec_t;
  vec_t tbl[14];

  initial begin
    // ldi r16,5 (no MEM), then push r16 with 3 wait states, then a frozen IF
    tbl[0]  = '{1, 0, 0, 5'b00001, 1, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 5'b00010, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 5'b00100, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 5'b10000, 0, 1, 0, 0};
    tbl[4]  = '{1, 0, 1, 5'b00001, 1, 0, 0, 0};
    tbl[5]  = '{1, 0, 1, 5'b00010, 0, 0, 0, 0};
    tbl[6]  = '{1, 1, 0, 5'b00100, 0, 0, 0, 0};
    tbl[7]  = '{1, 1, 0, 5'b01000, 0, 0, 0, 0};
    tbl[8]  = '{1, 1, 0, 5'b01000, 0, 0, 0, 1};
    tbl[9]  = '{1, 1, 0, 5'b01000, 0, 0, 0, 2};
    tbl[10] = '{1, 1, 1, 5'b01000, 0, 0, 0, 3};
    tbl[11] = '{1, 0, 0, 5'b10000, 0, 1, 0, 0};
    tbl[12] = '{0, 0, 0, 5'b00001, 0, 0, 0, 0};
    tbl[13] = '{1, 0, 0, 5'b00001, 1, 0, 0, 0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stage", stage, 1);
    chk("rst_wait", wc, 0);
    chk("rst_timeout", tout, 0);
    chk("rst_suppress", sup, 0);
    chk("rst_pc_update", pc, 0);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      tick_a(tbl[i].r, tbl[i].m, tbl[i].b);
      chk($sformatf("vec%0d_stage", i), stage, tbl[i].st);
      chk($sformatf("vec%0d_il", i), il, tbl[i].il);
      chk($sformatf("vec%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("vec%0d_sup", i), sup, tbl[i].sup);
      chk($sformatf("vec%0d_wc", i), wc, tbl[i].wc);
      tick_b();
    end
    chk("push_stalls", sc, PERF ? 3 : 0);
    chk("two_retired", ic, PERF ? 2 : 0);
    run_to_if();

    // hung bus: 16 MEM cycles then WB with suppress; bus_ready ignored outside MEM
    tick(1, 0, 1); tick(1, 0, 1); tick(1, 1, 0);
    for (int k = 0; k < MAXW + 1; k++) begin
      tick_a(1, 1, 0);
      chk("to_in_mem", stage, 5'b01000);
      tick_b();
    end
    tick_a(1, 0, 0);
    chk("to_wb", stage, 5'b10000);
    chk("to_sup", sup, 1);
    chk("to_flag", tout, 1);
    chk("to_pc", pc, 1);
    tick_b();
    tick_a(1, 0, 0);
    chk("to_next_if", stage, 5'b00001);
    chk("to_sup_clr", sup, 0);
    chk("to_sticky", tout, 1);
    tick_b();

    // freeze in EX and in MEM with bus_ready held
    tick(1, 0, 0);
    repeat (5) tick(0, 1, 1);
    chk("frz_ex", stage, 5'b00100);
    tick(1, 1, 0);
    tick(1, 1, 0);
    repeat (5) tick(0, 1, 1);
    chk("frz_mem", stage, 5'b01000);
    chk("frz_wc", wc, 1);
    tick(1, 1, 1);
    chk("frz_resume", stage, 5'b10000);
    run_to_if();

    // reset in the middle of MEM
    tick(1, 0, 0); tick(1, 0, 0); tick(1, 1, 0); tick(1, 1, 0); tick(1, 1, 0);
    run = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_stage", stage, 1);
    chk("mid_rst_timeout", tout, 0);
    chk("mid_rst_wc", wc, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_hold", stage, 1);
    reset = 1'b1;
    tick(1, 0, 0);
    tick_a(1, 0, 0);
    chk("rel_id", stage, 5'b00010);
    tick_b();

    // random traffic
    for (int k = 0; k < 1500; k++)
      tick($urandom_range(0, 9) < 8, $urandom_range(0, 1), $urandom_range(0, 9) < 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_stage_sequencer.md
Name: cpu_stage_sequencer

Overview:
Multicycle stage controller for the CPU core. Sequences a one-hot pipeline_stage through IF, ID, EX, MEM and WB. Skips MEM for instructions with no data-bus access. Holds MEM while the data bus inserts wait states, and aborts a hung access via a watchdog. Drives the stage vector seen by control, reg_file and the unit-test bench, plus the PC-update and instruction-latch strobes.

Parameters:
STAGE_COUNT, 5, width of one-hot stage vector (bit0=IF, bit1=ID, bit2=EX, bit3=MEM, bit4=WB)
WAIT_WIDTH, 4, width of MEM wait-state counter
MAX_WAIT, 15, wait cycles in MEM before timeout abort (1..2^WAIT_WIDTH-1)
CNT_WIDTH, 16, width of performance counters (optional feature)

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-low reset
run  input  1  1 = sequencer advances; 0 = freeze in current stage
mem_access  input  1  from decoder, valid while stage is EX: instruction uses data bus (ld/st/push/pop)
bus_ready  input  1  data bus completes access this cycle (sampled in MEM only)
pipeline_stage  output  STAGE_COUNT  one-hot current stage
instr_latch  output  1  one-cycle strobe in IF: latch instruction word
pc_update  output  1  one-cycle strobe in WB: PC/branch target written
wb_suppress  output  1  high in WB following a timed-out MEM; register/SP writeback must be blocked
bus_timeout  output  1  sticky error flag
wait_count  output  WAIT_WIDTH  current MEM wait-state count
instr_count  output  CNT_WIDTH  retired instructions (optional feature)
stall_count  output  CNT_WIDTH  MEM wait cycles (optional feature)

Behaviour:
- Reset (reset=0, asynchronous): pipeline_stage=5'b00001 (IF); wait_count=0; bus_timeout=0; wb_suppress=0; counters=0. instr_latch and pc_update are combinational: instr_latch=1 while in IF with run=1, else 0; pc_update=0.
- Reset deasserted: first rising edge with run=1 completes IF and moves to ID.
- State register: exactly one stage bit is high at all times. Any non-one-hot value, which is unreachable, recovers to IF on the next edge.
- Transitions, only taken when run=1 (run=0 holds state, counters and strobes low):
  IF -> ID. ID -> EX. EX -> MEM if mem_access=1, else EX -> WB. MEM -> WB when bus_ready=1 or timeout. WB -> IF.
- Strobes: instr_latch=1 in IF with run=1. pc_update=1 in WB with run=1. Each is one cycle per instruction. Minimum latency: 4 cycles/instr without MEM, 5 with MEM and zero waits.
- MEM wait handling:
  - Entering MEM sets wait_count=0.
  - Each MEM cycle with bus_ready=0 increments wait_count.
  - If bus_ready=0 while wait_count==MAX_WAIT: go to WB, set bus_timeout=1 (sticky until reset), set wb_suppress=1 for that WB.
  - wait_count is cleared on leaving MEM.
  - bus_ready=1 on the first MEM cycle gives zero waits.
  - bus_ready in stages other than MEM is ignored.
- wb_suppress clears on the WB->IF transition. pc_update still fires in a suppressed WB; the PC advances past the faulting instruction.
- Simultaneous run=0 with bus_ready=1 in MEM: the state holds, and the bus must hold bus_ready until run returns. The wait counter does not increment while run=0.
- Reset mid-instruction: immediate return to IF, no strobes; the partially executed instruction is abandoned.

Optional Feature:
STAGE_PERF_CNT_EN: when defined, instr_count increments on every WB->IF transition and stall_count increments on every MEM cycle with run=1 and bus_ready=0. Both saturate at 2^CNT_WIDTH-1 and reset to 0. When undefined, both ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset held low 3 cycles, mid-MEM -> pipeline_stage=5'b00001 immediately, bus_timeout=0; release with run=1 -> ID after 1 edge.
- mem_access=0 instruction (ldi r16,5), run=1 -> stage sequence 1,2,4,16,1; pc_update high exactly 1 cycle in WB; 4 cycles total.
- push r16 with mem_access=1, bus_ready high after 3 MEM cycles -> MEM lasts 4 cycles, wait_count reaches 3, stall_count=3 (STAGE_PERF_CNT_EN), wb_suppress=0.
- mem_access=1, bus_ready never asserted, MAX_WAIT=15 -> WB after 16 MEM cycles, bus_timeout=1 and sticky, wb_suppress=1 for that WB only, next IF proceeds.
- run=0 for 5 cycles during EX and during MEM with bus_ready=1 -> stage frozen, no strobes, wait_count unchanged; resumes correctly when run=1.
- 10 back-to-back instructions, mixed mem_access -> instr_count=10; with CNT_WIDTH=4 and 20 instructions, instr_count saturates at 15.
